// File: rtl/decode_pkg.sv
// Shared encodings for the decode stage: forwarding selects, next-PC selects
// and bit positions inside the branch-condition vector.
package decode_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam logic [1:0] PC_SEL_BR  = 2'b00;
    localparam logic [1:0] PC_SEL_JR  = 2'b01;
    localparam logic [1:0] PC_SEL_J   = 2'b10;
    localparam logic [1:0] PC_SEL_SEQ = 2'b11;

    localparam int COND_EQ   = 0;
    localparam int COND_GTZ  = 1;
    localparam int COND_LTZ  = 2;
    localparam int COND_LTEZ = 3;

    localparam int COND_W = 4;

endpackage

// File: rtl/decode_stage_pipe_reg_file_bypass.sv
// 2-read / 1-write register file with write-through bypass; when ZERO_REG is
// set, register 0 always reads zero and discards writes.
module reg_file_bypass #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] ra1_i,
    input  logic [ADDR_WIDTH-1:0] ra2_i,
    output logic [DATA_WIDTH-1:0] rd1_o,
    output logic [DATA_WIDTH-1:0] rd2_o,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] wa_i,
    input  logic [DATA_WIDTH-1:0] wd_i
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic                  wr_en;

    assign wr_en = we_i && !((ZERO_REG != 0) && (wa_i == '0));

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wa_i] = wd_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Write data is visible to a read of the same address in the same cycle.
    always_comb begin
        rd1_o = mem_q[ra1_i];
        rd2_o = mem_q[ra2_i];
        if (wr_en && (wa_i == ra1_i)) rd1_o = wd_i;
        if (wr_en && (wa_i == ra2_i)) rd2_o = wd_i;
        if ((ZERO_REG != 0) && (ra1_i == '0)) rd1_o = '0;
        if ((ZERO_REG != 0) && (ra2_i == '0)) rd2_o = '0;
    end

endmodule

// File: rtl/decode_stage_pipe.sv
// ID stage with operand forwarding, branch compares, next-PC selection and an
// elastic ID/EX register. Optional stall counter: define DECODE_STALL_CNT_EN.
module decode_stage_pipe
    import decode_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int INSTR_WIDTH   = 32,
    parameter int RF_ADDR_WIDTH = 5,
    parameter int ZERO_REG      = 1
) (
    input  logic                     i_CLK,
    input  logic                     i_RST,
    input  logic                     i_ValidD,
    output logic                     o_ReadyD,
    input  logic [INSTR_WIDTH-1:0]   i_InstrD,
    input  logic [ADDRESS_WIDTH-1:0] i_PCPlus4D,
    input  logic                     i_sign_selD,
    input  logic [1:0]               i_PC_SELD,
    input  logic [1:0]               i_ForwardAD,
    input  logic [1:0]               i_ForwardBD,
    input  logic [DATA_WIDTH-1:0]    i_ALUOutM,
    input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegW,
    input  logic                     i_RegWriteW,
    input  logic [DATA_WIDTH-1:0]    i_ResultW,
    input  logic                     i_FlushE,
    input  logic                     i_ReadyE,
    output logic [ADDRESS_WIDTH-1:0] o_PCNextD,
    output logic [COND_W-1:0]        o_CondD,
    output logic                     o_ValidE,
    output logic [DATA_WIDTH-1:0]    o_SrcAE,
    output logic [DATA_WIDTH-1:0]    o_SrcBE,
    output logic [DATA_WIDTH-1:0]    o_SignImmE,
    output logic [RF_ADDR_WIDTH-1:0] o_RsE,
    output logic [RF_ADDR_WIDTH-1:0] o_RtE,
    output logic [RF_ADDR_WIDTH-1:0] o_RdE,
    output logic [4:0]               o_ShamtE
`ifdef DECODE_STALL_CNT_EN
    ,output logic [31:0]             o_StallCnt
`endif
);

    logic [RF_ADDR_WIDTH-1:0] rs, rt, rd;
    logic [4:0]               shamt;
    logic [15:0]              imm16;
    logic [DATA_WIDTH-1:0]    rf_rd1, rf_rd2, fwd_a, fwd_b, ext_imm;
    logic [ADDRESS_WIDTH-1:0] br_off;
    logic                     load;
    logic                     unused_opcode;

    assign rs    = RF_ADDR_WIDTH'(i_InstrD[25:21]);
    assign rt    = RF_ADDR_WIDTH'(i_InstrD[20:16]);
    assign rd    = RF_ADDR_WIDTH'(i_InstrD[15:11]);
    assign shamt = i_InstrD[10:6];
    assign imm16 = i_InstrD[15:0];
    assign unused_opcode = &{i_InstrD[INSTR_WIDTH-1:26], 1'b0};

    reg_file_bypass #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(RF_ADDR_WIDTH),
        .ZERO_REG  (ZERO_REG)
    ) u_rf (
        .clk  (i_CLK),
        .rst_n(i_RST),
        .ra1_i(rs),
        .ra2_i(rt),
        .rd1_o(rf_rd1),
        .rd2_o(rf_rd2),
        .we_i (i_RegWriteW),
        .wa_i (i_WriteRegW),
        .wd_i (i_ResultW)
    );

    always_comb begin
        fwd_a = rf_rd1;
        fwd_b = rf_rd2;
        case (i_ForwardAD)
            FWD_MEM: fwd_a = i_ALUOutM;
            FWD_WB:  fwd_a = i_ResultW;
            default: fwd_a = rf_rd1;
        endcase
        case (i_ForwardBD)
            FWD_MEM: fwd_b = i_ALUOutM;
            FWD_WB:  fwd_b = i_ResultW;
            default: fwd_b = rf_rd2;
        endcase
    end

    // Signed compares against zero only need the sign bit and a zero test.
    always_comb begin
        o_CondD            = '0;
        o_CondD[COND_EQ]   = (fwd_a == fwd_b);
        o_CondD[COND_LTZ]  = fwd_a[DATA_WIDTH-1];
        o_CondD[COND_GTZ]  = !fwd_a[DATA_WIDTH-1] && (fwd_a != '0);
        o_CondD[COND_LTEZ] = fwd_a[DATA_WIDTH-1] || (fwd_a == '0);
    end

    assign ext_imm = i_sign_selD ? {{(DATA_WIDTH-16){1'b0}}, imm16}
                                 : {{(DATA_WIDTH-16){imm16[15]}}, imm16};
    // Branch offset is always sign-extended regardless of i_sign_selD.
    assign br_off  = {{(ADDRESS_WIDTH-18){imm16[15]}}, imm16, 2'b00};

    always_comb begin
        o_PCNextD = i_PCPlus4D;
        case (i_PC_SELD)
            PC_SEL_BR: o_PCNextD = i_PCPlus4D + br_off;
            PC_SEL_JR: o_PCNextD = ADDRESS_WIDTH'(fwd_a);
            PC_SEL_J:  o_PCNextD = {i_PCPlus4D[ADDRESS_WIDTH-1:28], i_InstrD[25:0], 2'b00};
            default:   o_PCNextD = i_PCPlus4D;
        endcase
    end

    logic                     valid_q, valid_d;
    logic [DATA_WIDTH-1:0]    src_a_q, src_a_d, src_b_q, src_b_d, sign_imm_q, sign_imm_d;
    logic [RF_ADDR_WIDTH-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [4:0]               shamt_q, shamt_d;

    assign o_ReadyD = !valid_q || i_ReadyE;
    assign load     = i_ValidD && o_ReadyD;

    // Flush wins over load and stall; a flushed payload is left for EX to ignore.
    always_comb begin
        valid_d    = valid_q;
        src_a_d    = src_a_q;
        src_b_d    = src_b_q;
        sign_imm_d = sign_imm_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        rd_d       = rd_q;
        shamt_d    = shamt_q;
        if (load) begin
            src_a_d    = rf_rd1;
            src_b_d    = rf_rd2;
            sign_imm_d = ext_imm;
            rs_d       = rs;
            rt_d       = rt;
            rd_d       = rd;
            shamt_d    = shamt;
        end
        if (i_FlushE)             valid_d = 1'b0;
        else if (load)            valid_d = 1'b1;
        else if (valid_q && i_ReadyE) valid_d = 1'b0;
    end

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            valid_q    <= 1'b0;
            src_a_q    <= '0;
            src_b_q    <= '0;
            sign_imm_q <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
            shamt_q    <= '0;
        end else begin
            valid_q    <= valid_d;
            src_a_q    <= src_a_d;
            src_b_q    <= src_b_d;
            sign_imm_q <= sign_imm_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            rd_q       <= rd_d;
            shamt_q    <= shamt_d;
        end
    end

    assign o_ValidE   = valid_q;
    assign o_SrcAE    = src_a_q;
    assign o_SrcBE    = src_b_q;
    assign o_SignImmE = sign_imm_q;
    assign o_RsE      = rs_q;
    assign o_RtE      = rt_q;
    assign o_RdE      = rd_q;
    assign o_ShamtE   = shamt_q;

`ifdef DECODE_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (i_ValidD && !o_ReadyD && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign o_StallCnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe: bypass, zero register, compares,
// next-PC, stall/flush/drain and asynchronous reset.
module tb_decode_stage_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_d, ready_d;
    logic [31:0] instr_d, pc_plus4_d;
    logic        sign_sel_d;
    logic [1:0]  pc_sel_d, fwd_a_d, fwd_b_d;
    logic [31:0] alu_out_m, result_w;
    logic [4:0]  write_reg_w;
    logic        reg_write_w, flush_e, ready_e;
    logic [31:0] pc_next_d;
    logic [3:0]  cond_d;
    logic        valid_e;
    logic [31:0] src_a_e, src_b_e, sign_imm_e;
    logic [4:0]  rs_e, rt_e, rd_e, shamt_e;
`ifdef DECODE_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    decode_stage_pipe dut (
        .i_CLK      (clk),
        .i_RST      (rst_n),
        .i_ValidD   (valid_d),
        .o_ReadyD   (ready_d),
        .i_InstrD   (instr_d),
        .i_PCPlus4D (pc_plus4_d),
        .i_sign_selD(sign_sel_d),
        .i_PC_SELD  (pc_sel_d),
        .i_ForwardAD(fwd_a_d),
        .i_ForwardBD(fwd_b_d),
        .i_ALUOutM  (alu_out_m),
        .i_WriteRegW(write_reg_w),
        .i_RegWriteW(reg_write_w),
        .i_ResultW  (result_w),
        .i_FlushE   (flush_e),
        .i_ReadyE   (ready_e),
        .o_PCNextD  (pc_next_d),
        .o_CondD    (cond_d),
        .o_ValidE   (valid_e),
        .o_SrcAE    (src_a_e),
        .o_SrcBE    (src_b_e),
        .o_SignImmE (sign_imm_e),
        .o_RsE      (rs_e),
        .o_RtE      (rt_e),
        .o_RdE      (rd_e),
        .o_ShamtE   (shamt_e)
`ifdef DECODE_STALL_CNT_EN
        ,.o_StallCnt(stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_i(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [15:0] imm);
        return {6'h23, rs, rt, imm};
    endfunction

    initial begin
        rst_n = 1'b0; valid_d = 1'b0; instr_d = '0; pc_plus4_d = '0; sign_sel_d = 1'b0;
        pc_sel_d = 2'b11; fwd_a_d = 2'b00; fwd_b_d = 2'b00; alu_out_m = '0; result_w = '0;
        write_reg_w = '0; reg_write_w = 1'b0; flush_e = 1'b0; ready_e = 1'b1;

        #2;
        check("rst_valid_e", 32'(valid_e), 32'd0);
        check("rst_src_a", src_a_e, 32'h0);
        check("rst_ready_d", 32'(ready_d), 32'd1);
        #10 rst_n = 1'b1;
        tick();

        // Write R5 and read it in the same cycle.
        reg_write_w = 1'b1; write_reg_w = 5'd5; result_w = 32'h1234;
        valid_d = 1'b1; instr_d = mk_i(5'd5, 5'd0, 16'h0010); sign_sel_d = 1'b0;
        #1 check("bypass_cond_gtz", 32'(cond_d), 32'h2);
        tick();
        check("load_valid_e", 32'(valid_e), 32'd1);
        check("bypass_src_a", src_a_e, 32'h1234);
        check("load_src_b_r0", src_b_e, 32'h0);
        check("load_sign_imm", sign_imm_e, 32'h10);
        check("load_rs", 32'(rs_e), 32'd5);
        reg_write_w = 1'b0; instr_d = mk_i(5'd5, 5'd0, 16'h8001);
        tick();
        check("rf_src_a_held", src_a_e, 32'h1234);
        check("sext_imm", sign_imm_e, 32'hFFFF_8001);
        check("rd_field", 32'(rd_e), 32'd16);

        // Writes to R0 are discarded.
        reg_write_w = 1'b1; write_reg_w = 5'd0; result_w = 32'hFFFF;
        instr_d = mk_i(5'd0, 5'd0, 16'hFFFF); sign_sel_d = 1'b1;
        tick();
        check("r0_bypass_blocked", src_a_e, 32'h0);
        check("zext_imm", sign_imm_e, 32'h0000_FFFF);
        check("rd_31", 32'(rd_e), 32'd31);
        check("shamt_31", 32'(shamt_e), 32'd31);
        reg_write_w = 1'b0;
        tick();
        check("r0_read_a", src_a_e, 32'h0);
        check("r0_read_b", src_b_e, 32'h0);

        // Drain with no new instruction, while writing R7 = -1.
        valid_d = 1'b0; reg_write_w = 1'b1; write_reg_w = 5'd7; result_w = 32'hFFFF_FFFF;
        tick();
        check("drain_valid_e", 32'(valid_e), 32'd0);
        check("drain_payload_held", sign_imm_e, 32'h0000_FFFF);
        reg_write_w = 1'b0; result_w = '0;

        // Signed compares on forwarded operands.
        instr_d = mk_i(5'd7, 5'd0, 16'h0);
        #1 check("cond_rf_neg", 32'(cond_d), 32'hC);
        fwd_a_d = 2'b01; alu_out_m = 32'd7;
        #1 check("cond_mem_pos", 32'(cond_d), 32'h2);
        fwd_b_d = 2'b01;
        #1 check("cond_mem_eq", 32'(cond_d), 32'h3);
        fwd_b_d = 2'b00; fwd_a_d = 2'b10;
        #1 check("cond_wb_zero", 32'(cond_d), 32'h9);
        fwd_a_d = 2'b11; pc_sel_d = 2'b01;
        #1 check("cond_code11_rf", 32'(cond_d), 32'hC);
        check("pc_jr", pc_next_d, 32'hFFFF_FFFF);
        fwd_a_d = 2'b00;

        // Next-PC candidates.
        pc_plus4_d = 32'h100; instr_d = mk_i(5'd0, 5'd0, 16'hFFFF); sign_sel_d = 1'b1; pc_sel_d = 2'b00;
        #1 check("pc_branch_back", pc_next_d, 32'hFC);
        instr_d = mk_i(5'd0, 5'd0, 16'h0004);
        #1 check("pc_branch_fwd", pc_next_d, 32'h110);
        instr_d = {6'h02, 26'h40}; pc_sel_d = 2'b10;
        #1 check("pc_jump_low", pc_next_d, 32'h100);
        pc_plus4_d = 32'h2000_0004;
        #1 check("pc_jump_region", pc_next_d, 32'h2000_0100);
        pc_sel_d = 2'b11;
        #1 check("pc_seq", pc_next_d, 32'h2000_0004);
        tick();

        // Stall: EX not ready, ID keeps presenting.
        valid_d = 1'b1; ready_e = 1'b0; instr_d = mk_i(5'd5, 5'd0, 16'h1111); sign_sel_d = 1'b0;
        tick();
        check("stall_load_valid", 32'(valid_e), 32'd1);
        check("stall_ready_d", 32'(ready_d), 32'd0);
        check("stall_load_a", src_a_e, 32'h1234);
        instr_d = mk_i(5'd7, 5'd0, 16'h2222);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid_e", 32'(valid_e), 32'd1);
            check("stall_ready_d_hold", 32'(ready_d), 32'd0);
            check("stall_src_a_frozen", src_a_e, 32'h1234);
            check("stall_imm_frozen", sign_imm_e, 32'h1111);
        end
`ifdef DECODE_STALL_CNT_EN
        check("stall_cnt_3", stall_cnt, 32'd3);
`endif
        ready_e = 1'b1;
        #1 check("release_ready_d", 32'(ready_d), 32'd1);
        tick();
        check("release_valid_e", 32'(valid_e), 32'd1);
        check("release_src_a", src_a_e, 32'hFFFF_FFFF);
        check("release_imm", sign_imm_e, 32'h2222);
        check("release_rs", 32'(rs_e), 32'd7);

        // Flush beats a stalled entry and a pending load.
        ready_e = 1'b0;
        tick();
        check("pre_flush_valid", 32'(valid_e), 32'd1);
        flush_e = 1'b1;
        tick();
        check("flush_valid_e", 32'(valid_e), 32'd0);
        flush_e = 1'b0;
        tick();
        check("reload_valid_e", 32'(valid_e), 32'd1);
        tick();

        // Asynchronous reset while stalled.
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(valid_e), 32'd0);
        check("async_rst_src_a", src_a_e, 32'h0);
        check("async_rst_imm", sign_imm_e, 32'h0);
        check("async_rst_rs", 32'(rs_e), 32'd0);
        check("async_rst_ready_d", 32'(ready_d), 32'd1);
`ifdef DECODE_STALL_CNT_EN
        check("async_rst_cnt", stall_cnt, 32'd0);
`endif
        #3 rst_n = 1'b1;
        valid_d = 1'b0; ready_e = 1'b1; instr_d = mk_i(5'd5, 5'd7, 16'h0);
        #1 check("rf_cleared_cond", 32'(cond_d), 32'h9);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
